// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment scan controller.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam int CNT_W      = 16;

  typedef logic [3:0]       bcd_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [6:0]       seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam an_t AN_OFF = 4'b1111;

  // Active-low one-cold anode pattern selecting a single digit.
  function automatic an_t an_select(input idx_t idx);
    return ~(an_t'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit to seven-segment decoder; codes 10-15 show a dash.
import seg7_pkg::*;

module bcd_to_seg7 (
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    // NOTE: a default on every path keeps a combinational block from inferring a latch.
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with registered outputs.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
import seg7_pkg::*;

module seg7_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  idx_t                         idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]        shadow_q, shadow_d;
  an_t                          an_q, an_d;
  seg_t                         seg_q, seg_d;
  logic                         frame_done_q, frame_done_d;

  logic tick;
  bcd_t digit_sel;
  seg_t digit_seg;
  logic blank;

  assign tick      = (cnt_q == CNT_LAST);
  assign digit_sel = shadow_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd (digit_sel),
    .seg (digit_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] is_zero;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      is_zero[i] = (shadow_q[i] == 4'd0);
    end
  end

  // A digit blanks only if it and every digit to its left are zero; ones never blanks.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = &is_zero[3:1];
      2'd2:    blank = &is_zero[3:2];
      2'd3:    blank = is_zero[3];
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 1'b1 : idx_q;
    shadow_d = load ? {thousands, hundreds, tens, ones} : shadow_q;
  end

  // Outputs hold between ticks; the decode reads the shadow value from before this edge.
  always_comb begin
    an_d         = an_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    if (tick) begin
      an_d         = an_select(idx_q);
      seg_d        = blank ? SEG_BLANK : digit_seg;
      frame_done_d = (idx_q == idx_t'(NUM_DIGITS - 1));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl at PRESCALE=4, with a slot-arithmetic reference model.
// Expected blanking follows SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] ones, tens, hundreds, thousands;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since the last reset edge and the captured digits.
  int          m_n;
  logic [15:0] m_shadow;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_fd;
  logic [6:0]  seg_tab [16];
  int          fd_count;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
  localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_pattern(input int d, input logic [15:0] sh);
    logic [3:0] digit;
    digit = sh[4*d +: 4];
`ifdef SEG7_LZ_BLANK_EN
    if (d > 0 && (sh >> (4*d)) == 16'd0) return 7'b1111111;
`endif
    return seg_tab[digit];
  endfunction

  // One clock edge: advance the model from the inputs present at the edge, then compare.
  task automatic step();
    int d;
    @(posedge clk);
    if (reset) begin
      m_n = 0; m_shadow = '0; m_an = 4'b1111; m_seg = 7'b1111111; m_fd = 1'b0;
    end else begin
      m_n++;
      m_fd = 1'b0;
      if (m_n % P == 0) begin
        d     = ((m_n / P) - 1) % 4;
        m_an  = ~(4'b0001 << d);
        m_seg = exp_pattern(d, m_shadow);
        m_fd  = (d == 3);
      end
      if (load) m_shadow = {thousands, hundreds, tens, ones};
    end
    #1;
    check("an", 16'(an), 16'(m_an));
    check("seg", 16'(seg), 16'(m_seg));
    check("frame_done", 16'(frame_done), 16'(m_fd));
    check("an_onecold", 16'($countones(~an) <= 1), 16'd1);
    if (frame_done) fd_count++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the edge just taken was the tick that displayed digit d.
  task automatic run_to_slot(input int d);
    int budget;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!(m_n % P == 0 && m_n > 0 && ((m_n / P) - 1) % 4 == d) && budget < 64);
    check("slot_reached", 16'(budget < 64), 16'd1);
  endtask

  task automatic set_digits(input logic [15:0] v);
    {thousands, hundreds, tens, ones} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int budget;
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    m_n = 0; m_shadow = '0; m_an = 4'b1111; m_seg = 7'b1111111; m_fd = 1'b0;
    fd_count = 0;

    reset = 1'b1; load = 1'b0;
    {thousands, hundreds, tens, ones} = 16'h0000;
    #2;
    steps(2);
    check("reset_an", 16'(an), 16'h000f);
    check("reset_seg", 16'(seg), 16'h007f);

    // Basic scan with 0055 loaded on the first edge after release.
    reset = 1'b0;
    set_digits(16'h0055);
    steps(3);
    check("scan_d0_an", 16'(an), 16'b1110);
    check("scan_d0_seg", 16'(seg), 16'b0010010);
    steps(4);
    check("scan_d1_an", 16'(an), 16'b1101);
    check("scan_d1_seg", 16'(seg), 16'b0010010);

    // Leading zeros of 0055.
    run_to_slot(2);
    check("lz_hundreds", 16'(seg), 16'(LEAD_ZERO));
    run_to_slot(3);
    check("lz_thousands", 16'(seg), 16'(LEAD_ZERO));

    // frame_done: exactly two pulses in 32 cycles, each while digit 3 is lit.
    fd_count = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_done) check("fd_with_an3", 16'(an), 16'b0111);
    end
    check("fd_count", 16'(fd_count), 16'd2);

    // All-zero value: only the ones digit shows a zero when blanking is on.
    set_digits(16'h0000);
    run_to_slot(0);
    check("zero_d0", 16'(seg), 16'b1000000);
    run_to_slot(1);
    check("zero_d1", 16'(seg), 16'(LEAD_ZERO));
    run_to_slot(3);
    check("zero_d3", 16'(seg), 16'(LEAD_ZERO));

    // Dash for an out-of-range ones digit.
    set_digits(16'h000A);
    run_to_slot(0);
    check("dash_d0", 16'(seg), 16'b0111111);

    // Load coinciding with the digit-0 tick: old value shown now, new value a frame later.
    budget = 0;
    while (!((m_n + 1) % P == 0 && (((m_n + 1) / P) - 1) % 4 == 0) && budget < 64) begin
      step();
      budget++;
    end
    check("coincide_aligned", 16'(budget < 64), 16'd1);
    set_digits(16'h0007);
    check("coincide_old_an", 16'(an), 16'b1110);
    check("coincide_old_seg", 16'(seg), 16'b0111111);
    steps(16);
    check("coincide_new_an", 16'(an), 16'b1110);
    check("coincide_new_seg", 16'(seg), 16'b1111000);

    // Reset asserted while digit 2 is lit.
    set_digits(16'h1234);
    run_to_slot(2);
    check("midscan_an2", 16'(an), 16'b1011);
    reset = 1'b1;
    step();
    check("midscan_reset_an", 16'(an), 16'b1111);
    check("midscan_reset_seg", 16'(seg), 16'b1111111);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midscan_idle_an", 16'(an), 16'b1111);
    end
    step();
    check("midscan_first_an", 16'(an), 16'b1110);
    check("midscan_first_seg", 16'(seg), 16'b1000000);

    // Random loads and digits, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      ones      = 4'($urandom_range(0, 15));
      tens      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      hundreds  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      thousands = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; load = 1'b0;
    steps(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
